// File: rtl/tzfe_pkg.sv
// tzfe_pkg: shared direction, arbiter-state and debounce definitions for the 2048 input path.
package tzfe_pkg;
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        LOCK = 2'd2
    } arb_state_t;

    localparam int DEBOUNCE_DEFAULT = 16;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, debounce counter and registered rising-edge pulse for one button.
module btn_debounce
    import tzfe_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level;

    // cnt tracks consecutive synchronised samples that disagree with the current level
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                rise  <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/move_arbiter.sv
// move_arbiter: debounces the direction/start buttons and delivers one round-robin arbitrated
// move command per press over a valid/ready handshake, with lockout while the game is over or won.
module move_arbiter
    import tzfe_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int DROP_W          = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [3:0]        btn_in,
    input  logic              start_in,
    input  logic              game_over,
    input  logic              game_win,
    input  logic              move_ready,
    output logic              move_valid,
    output logic [1:0]        move_dir,
    output logic              start_pulse,
    output logic [DROP_W-1:0] drop_count
);
    localparam int SW = DROP_W + 3;

    logic [3:0]        ev;
    logic              st_ev;
    arb_state_t        state;
    dir_t              last_grant;
    dir_t              win;
    logic              found;
    logic              lk;
    logic              xfer;
    logic [1:0]        idx;
    logic [2:0]        n_ev;
    logic [2:0]        inc;
    logic [SW-1:0]     sum;
    logic [DROP_W-1:0] drop_nx;

    for (genvar i = 0; i < 4; i++) begin : g_dir
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .Clk  (Clk),
            .Reset(Reset),
            .raw  (btn_in[i]),
            .rise (ev[i])
        );
    end

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .Clk  (Clk),
        .Reset(Reset),
        .raw  (start_in),
        .rise (st_ev)
    );

    always_comb begin
        win   = last_grant;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = 2'(last_grant + k);
            if (ev[idx] && !found) begin
                found = 1'b1;
                win   = dir_t'(idx);
            end
        end
        n_ev = 3'(ev[0]) + 3'(ev[1]) + 3'(ev[2]) + 3'(ev[3]);
        lk   = game_over | game_win;
        xfer = move_valid & move_ready;
        // a granted event that cannot be loaded is counted together with the losers
        inc = (st_ev || lk || state == LOCK || !found) ? 3'd0 :
              (state == PEND && !xfer) ? n_ev : n_ev - 3'd1;
        sum     = SW'(drop_count) + SW'(inc);
        drop_nx = (sum > SW'({DROP_W{1'b1}})) ? '1 : sum[DROP_W-1:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            last_grant  <= DIR_RIGHT;
            move_valid  <= 1'b0;
            move_dir    <= '0;
            start_pulse <= 1'b0;
            drop_count  <= '0;
        end else begin
            start_pulse <= st_ev;
            drop_count  <= drop_nx;
            if (st_ev || lk) begin
                move_valid <= 1'b0;
                state      <= lk ? LOCK : IDLE;
            end else if (state == LOCK) begin
                state <= IDLE;
            end else if (found && (state == IDLE || xfer)) begin
                move_valid <= 1'b1;
                move_dir   <= win;
                state      <= PEND;
            end else if (xfer) begin
                move_valid <= 1'b0;
                state      <= IDLE;
            end
            if (!st_ev && !lk && state != LOCK && found)
                last_grant <= win;
        end
    end
endmodule

// File: tb/tb_move_arbiter.sv
// tb_move_arbiter: vector table, hand-written corner sequences and random stimulus against a
// sample-window reference model of move_arbiter.
module tb_move_arbiter;
    localparam int DB   = 4;
    localparam int DW   = 4;
    localparam int MAXD = (1 << DW) - 1;

    typedef struct {
        int b, s, go, gw, rdy, n, ev, ed, esp, edrop;
    } vec_t;

    logic          MAX10_CLK1_50 = 1'b0;
    logic          Reset         = 1'b1;
    logic [3:0]    btn_in        = '0;
    logic          start_in      = 1'b0;
    logic          game_over     = 1'b0;
    logic          game_win      = 1'b0;
    logic          move_ready    = 1'b0;
    logic          move_valid;
    logic [1:0]    move_dir;
    logic          start_pulse;
    logic [DW-1:0] drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    bit hist [5][DB+2];
    bit m_lvl [5];
    bit m_rise [5];
    int m_valid, m_dir, m_sp, m_drop, m_last;
    bit m_lock;

    vec_t tbl[$];

    always #5 MAX10_CLK1_50 = ~MAX10_CLK1_50;

    move_arbiter #(.DEBOUNCE_CYCLES(DB), .DROP_W(DW)) dut (
        .Clk        (MAX10_CLK1_50),
        .Reset      (Reset),
        .btn_in     (btn_in),
        .start_in   (start_in),
        .game_over  (game_over),
        .game_win   (game_win),
        .move_ready (move_ready),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .start_pulse(start_pulse),
        .drop_count (drop_count)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void mdl_reset();
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < DB + 2; k++) hist[c][k] = 1'b0;
            m_lvl[c]  = 1'b0;
            m_rise[c] = 1'b0;
        end
        m_valid = 0; m_dir = 0; m_sp = 0; m_drop = 0; m_last = 3; m_lock = 1'b0;
    endfunction

    // One rising edge: each channel's debounced level follows the last DB synchronised samples
    // (raw delayed two edges) once they all agree; presses are served by the command slot.
    function automatic void mdl_edge(input int b, input int s, input int go, input int gw, input int rdy);
        int nev;
        int w;
        bit xfer;
        bit same;
        nev = 0;
        w = -1;
        for (int c = 0; c < 5; c++) begin
            for (int k = DB + 1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = (((c == 4) ? s : (b >> c)) & 1) != 0;
        end
        for (int d = 0; d < 4; d++) nev += int'(m_rise[d]);
        for (int k = 1; k <= 4; k++)
            if (w < 0 && m_rise[(m_last + k) % 4]) w = (m_last + k) % 4;
        xfer = (m_valid != 0) && (rdy != 0);
        m_sp = int'(m_rise[4]);
        if (m_rise[4]) begin
            m_valid = 0;
            m_lock  = (go | gw) != 0;
        end else if ((go | gw) != 0) begin
            m_valid = 0;
            m_lock  = 1'b1;
        end else if (m_lock) begin
            m_lock = 1'b0;
        end else if (w >= 0) begin
            m_last = w;
            if (m_valid == 0 || xfer) begin
                m_valid = 1;
                m_dir   = w;
                m_drop += nev - 1;
            end else begin
                m_drop += nev;
            end
        end else if (xfer) begin
            m_valid = 0;
        end
        if (m_drop > MAXD) m_drop = MAXD;
        for (int c = 0; c < 5; c++) begin
            same = 1'b1;
            for (int k = 3; k <= DB + 1; k++) if (hist[c][k] != hist[c][2]) same = 1'b0;
            m_rise[c] = 1'b0;
            if (same && hist[c][2] != m_lvl[c]) begin
                m_lvl[c]  = hist[c][2];
                m_rise[c] = hist[c][2];
            end
        end
    endfunction

    task automatic step(input int b, input int s, input int go, input int gw, input int rdy);
        btn_in     = 4'(b);
        start_in   = s[0];
        game_over  = go[0];
        game_win   = gw[0];
        move_ready = rdy[0];
        @(posedge MAX10_CLK1_50);
        mdl_edge(b, s, go, gw, rdy);
        #1;
        chk("mdl_valid", int'(move_valid), m_valid);
        chk("mdl_start_pulse", int'(start_pulse), m_sp);
        chk("mdl_drop_count", int'(drop_count), m_drop);
        if (m_valid != 0) chk("mdl_move_dir", int'(move_dir), m_dir);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        btn_in = '0; start_in = 1'b0; game_over = 1'b0; game_win = 1'b0; move_ready = 1'b0;
        mdl_reset();
        repeat (2) @(posedge MAX10_CLK1_50);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        // fields: b, s, go, gw, rdy, cycles, valid, dir, start_pulse, drop
        tbl.push_back('{15, 0, 0, 0, 1,  7, 1, 0, 0,  3});
        tbl.push_back('{ 0, 0, 0, 0, 1,  8, 0, 0, 0,  3});
        tbl.push_back('{15, 0, 0, 0, 1,  7, 1, 1, 0,  6});
        tbl.push_back('{ 0, 0, 0, 0, 1,  8, 0, 0, 0,  6});
        tbl.push_back('{15, 0, 0, 0, 1,  7, 1, 2, 0,  9});
        tbl.push_back('{ 0, 0, 0, 0, 1,  8, 0, 0, 0,  9});
        tbl.push_back('{ 1, 0, 0, 0, 1,  6, 0, 0, 0,  9});
        tbl.push_back('{ 1, 0, 0, 0, 1,  1, 1, 0, 0,  9});
        tbl.push_back('{ 1, 0, 0, 0, 1, 13, 0, 0, 0,  9});
        tbl.push_back('{ 0, 0, 0, 0, 1,  8, 0, 0, 0,  9});
        tbl.push_back('{ 1, 0, 0, 0, 0,  7, 1, 0, 0,  9});
        tbl.push_back('{ 0, 0, 0, 0, 0,  8, 1, 0, 0,  9});
        tbl.push_back('{ 8, 0, 0, 0, 0,  7, 1, 0, 0, 10});
        tbl.push_back('{ 0, 0, 0, 0, 0,  8, 1, 0, 0, 10});
        tbl.push_back('{ 4, 0, 0, 0, 0,  6, 1, 0, 0, 10});
        tbl.push_back('{ 4, 0, 0, 0, 1,  1, 1, 2, 0, 10});
        tbl.push_back('{ 0, 0, 0, 0, 1,  1, 0, 0, 0, 10});
        tbl.push_back('{ 0, 0, 0, 0, 1,  7, 0, 0, 0, 10});
        tbl.push_back('{ 1, 0, 0, 0, 0,  7, 1, 0, 0, 10});
        tbl.push_back('{ 0, 0, 1, 0, 0,  1, 0, 0, 0, 10});
        tbl.push_back('{ 0, 0, 1, 0, 0,  7, 0, 0, 0, 10});
        tbl.push_back('{15, 0, 1, 0, 0,  7, 0, 0, 0, 10});
        tbl.push_back('{ 0, 0, 1, 0, 0,  8, 0, 0, 0, 10});
        tbl.push_back('{ 0, 0, 0, 0, 0,  1, 0, 0, 0, 10});
        tbl.push_back('{ 2, 0, 0, 0, 1,  7, 1, 1, 0, 10});
        tbl.push_back('{ 0, 0, 0, 0, 1,  8, 0, 0, 0, 10});
        tbl.push_back('{ 4, 0, 0, 1, 1,  7, 0, 0, 0, 10});
        tbl.push_back('{ 0, 0, 0, 0, 1,  8, 0, 0, 0, 10});
        tbl.push_back('{ 1, 1, 0, 0, 1,  6, 0, 0, 0, 10});
        tbl.push_back('{ 1, 1, 0, 0, 1,  1, 0, 0, 1, 10});
        tbl.push_back('{ 1, 1, 0, 0, 1,  1, 0, 0, 0, 10});
        tbl.push_back('{ 0, 0, 0, 0, 1,  8, 0, 0, 0, 10});

        mdl_reset();
        repeat (2) @(posedge MAX10_CLK1_50);
        #1;
        chk("reset_valid", int'(move_valid), 0);
        chk("reset_dir", int'(move_dir), 0);
        chk("reset_start_pulse", int'(start_pulse), 0);
        chk("reset_drop", int'(drop_count), 0);
        Reset = 1'b0;

        foreach (tbl[r]) begin
            repeat (tbl[r].n) step(tbl[r].b, tbl[r].s, tbl[r].go, tbl[r].gw, tbl[r].rdy);
            chk($sformatf("row%0d_valid", r), int'(move_valid), tbl[r].ev);
            if (tbl[r].ev != 0) chk($sformatf("row%0d_dir", r), int'(move_dir), tbl[r].ed);
            chk($sformatf("row%0d_start_pulse", r), int'(start_pulse), tbl[r].esp);
            chk($sformatf("row%0d_drop", r), int'(drop_count), tbl[r].edrop);
        end

        // left bounces in pairs for 12 cycles, then holds from cycle 13
        do_reset();
        for (int c = 1; c <= 30; c++) begin
            int b;
            b = (c <= 12 && ((c - 1) / 2) % 2 == 1) ? 0 : 4;
            step(b, 0, 0, 0, 1);
            chk($sformatf("bounce_valid_c%0d", c), int'(move_valid), int'(c == 19));
            if (c == 19) chk("bounce_dir", int'(move_dir), 2);
        end

        // pending right plus one drop, then asynchronous reset while up is mid-debounce
        repeat (7) step(10, 0, 0, 0, 0);
        chk("pre_rst_dir", int'(move_dir), 3);
        chk("pre_rst_drop", int'(drop_count), 1);
        repeat (3) step(11, 0, 0, 0, 0);
        #3;
        Reset = 1'b1;
        #1;
        chk("async_valid", int'(move_valid), 0);
        chk("async_dir", int'(move_dir), 0);
        chk("async_start_pulse", int'(start_pulse), 0);
        chk("async_drop", int'(drop_count), 0);
        mdl_reset();
        repeat (2) @(posedge MAX10_CLK1_50);
        #1;
        Reset = 1'b0;
        repeat (6) step(11, 0, 0, 0, 0);
        chk("restart_early", int'(move_valid), 0);
        step(11, 0, 0, 0, 0);
        chk("restart_valid", int'(move_valid), 1);
        chk("restart_dir", int'(move_dir), 0);
        chk("restart_drop", int'(drop_count), 2);

        repeat (8) step(0, 0, 0, 0, 0);
        repeat (4) begin
            repeat (7) step(15, 0, 0, 0, 0);
            repeat (8) step(0, 0, 0, 0, 0);
        end
        chk("sat_drop", int'(drop_count), MAXD);
        repeat (7) step(15, 0, 0, 0, 0);
        chk("sat_hold", int'(drop_count), MAXD);

        do_reset();
        begin
            int b, s, go, gw;
            b = 0; s = 0; go = 0; gw = 0;
            repeat (2000) begin
                for (int d = 0; d < 4; d++) if ($urandom_range(5) == 0) b ^= (1 << d);
                if ($urandom_range(39) == 0) s ^= 1;
                if ($urandom_range(59) == 0) go ^= 1;
                if ($urandom_range(79) == 0) gw ^= 1;
                step(b, s, go, gw, int'($urandom_range(1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
